// File: rtl/yarp_pkg.sv
// Shared types and helpers for the yarp fetch stage.
package yarp_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Increment by one when enabled, holding at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    if (en && (value != 32'hFFFF_FFFF)) begin
      return value + 32'd1;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/yarp_fetch_if.sv
// Memory-request and decode-handshake bundle of the fetch stage.
// master: the fetch stage; slave: memory port plus decode stage.
interface yarp_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            fetch_valid_o;
  logic [XLEN-1:0] fetch_pc_o;
  logic [XLEN-1:0] fetch_instr_o;
  logic            fetch_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, fetch_valid_o, fetch_pc_o, fetch_instr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, fetch_valid_o, fetch_pc_o, fetch_instr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i
  );

endinterface

// File: rtl/yarp_fetch_buf.sv
// Small FIFO of fetched {pc, instr} entries. Flush has priority over
// push/pop; the head reads as zero while the buffer is empty.
module yarp_fetch_buf
  import yarp_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign count   = count_q;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= AW'(0);
      wr_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= AW'(0);
      wr_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Present the oldest entry, or zeros when nothing is buffered.
  always_comb begin
    if (empty) begin
      head = '0;
    end else begin
      head = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/yarp_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one word request
// outstanding (only when a buffer slot is reserved for it), buffers
// responses and hands {pc, instr} to decode. Redirects flush the buffer
// and mark any in-flight response as stale.
// Optional: define YARP_FETCH_PERF_EN for saturating perf counters.
module yarp_fetch
  import yarp_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  yarp_fetch_if.master    fbus
`ifdef YARP_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_dropped_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic            buf_push, buf_pop, buf_flush, buf_empty;
  logic [CW-1:0]   buf_count, count_after;
  fetch_entry_t    wr_entry, head;
  logic            head_valid;

  assign head_valid         = !buf_empty;
  assign fbus.fetch_valid_o = head_valid;
  assign fbus.fetch_pc_o    = head.pc;
  assign fbus.fetch_instr_o = head.instr;
  assign fbus.mem_req_o     = (state_q == REQ);
  assign fbus.mem_addr_o    = pc_q;

  yarp_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (reset),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (buf_flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (buf_count),
    .empty    (buf_empty)
  );

  // FSM state, PC, request PC and stale-response flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state, PC update and buffer control; a redirect overrides all.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    drop_d         = drop_q;
    buf_push       = 1'b0;
    buf_pop        = 1'b0;
    buf_flush      = 1'b0;
    count_after    = buf_count;
    wr_entry.pc    = req_pc_q;
    wr_entry.instr = fbus.mem_rdata_i;

    if (redirect_valid_i) begin
      buf_flush = 1'b1;
      pc_d      = word_align(redirect_pc_i);
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (fbus.mem_gnt_i) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (fbus.mem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end else begin
      buf_pop = head_valid && fbus.fetch_ready_i;
      case (state_q)
        IDLE: begin
          if (buf_count < DEPTH_C) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (fbus.mem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_INCR;
            state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (fbus.mem_rvalid_i) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              buf_push = 1'b1;
            end
            count_after = buf_count + CW'(buf_push) - CW'(buf_pop);
            if (count_after < DEPTH_C) begin
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT;
          end
        end
        default: begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef YARP_FETCH_PERF_EN
  logic dropped;
  logic stalled;

  assign dropped = fbus.mem_rvalid_i && (state_q == WAIT) && (drop_q || redirect_valid_i);
  assign stalled = (buf_count == DEPTH_C) && !fbus.fetch_ready_i;

  // Saturating event counters for pushes, discarded responses and stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_o <= 32'd0;
      perf_dropped_o <= 32'd0;
      perf_stall_o   <= 32'd0;
    end else begin
      perf_fetched_o <= sat_inc32(perf_fetched_o, buf_push);
      perf_dropped_o <= sat_inc32(perf_dropped_o, dropped);
      perf_stall_o   <= sat_inc32(perf_stall_o, stalled);
    end
  end
`endif

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed self-checking bench for yarp_fetch with a variable-latency
// memory responder and a decode-side pop monitor.
module tb_yarp_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  yarp_fetch_if #(.XLEN(32)) fif ();

`ifdef YARP_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  yarp_fetch #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk              (clk),
    .reset            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .fbus             (fif.master)
`ifdef YARP_FETCH_PERF_EN
    ,
    .perf_fetched_o   (perf_fetched),
    .perf_dropped_o   (perf_dropped),
    .perf_stall_o     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // memory model controls (written by the stimulus process only)
  int lat = 1;
  bit gnt_allow = 1'b1;
  bit keep_on_rst = 1'b0;

  // memory model state
  bit          pend, gnt_issued;
  int          lat_cnt;
  logic [31:0] pend_addr, gnt_addr;
  logic [31:0] req_log [256];
  int          n_req = 0;

  // pop monitor state
  logic [31:0] pop_pc [256];
  logic [31:0] pop_instr [256];
  int          pop_cyc [256];
  int          n_pop = 0;

  int rb, pb;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_0013;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_reqs(input int target, input string tag);
    int k = 0;
    while (n_req < target && k < 300) begin
      tick();
      k++;
    end
    check_value(tag, 32'(n_req >= target), 32'd1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int k = 0;
    while (n_pop < target && k < 300) begin
      tick();
      k++;
    end
    check_value(tag, 32'(n_pop >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    rb = n_req;
    pb = n_pop;
  endtask

  // cycle counter for spacing checks
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder: grants when allowed, answers after lat cycles
  initial begin
    fif.mem_gnt_i    = 1'b0;
    fif.mem_rvalid_i = 1'b0;
    fif.mem_rdata_i  = 32'd0;
    pend = 1'b0;
    gnt_issued = 1'b0;
    lat_cnt = 0;
    pend_addr = 32'd0;
    gnt_addr = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      fif.mem_rvalid_i = 1'b0;
      fif.mem_gnt_i    = 1'b0;
      if (rst && !keep_on_rst) begin
        pend = 1'b0;
        gnt_issued = 1'b0;
      end else begin
        if (gnt_issued) begin
          pend = 1'b1;
          pend_addr = gnt_addr;
          lat_cnt = lat;
          gnt_issued = 1'b0;
        end
        if (pend) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            fif.mem_rvalid_i = 1'b1;
            fif.mem_rdata_i  = instr_of(pend_addr);
            pend = 1'b0;
          end
        end
        if (!rst && !pend && !fif.mem_rvalid_i && gnt_allow && fif.mem_req_o) begin
          fif.mem_gnt_i = 1'b1;
          gnt_issued = 1'b1;
          gnt_addr = fif.mem_addr_o;
          if (n_req < 256) req_log[n_req] = fif.mem_addr_o;
          n_req++;
        end
      end
    end
  end

  // decode-side monitor: records every accepted head entry
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && fif.fetch_valid_o && fif.fetch_ready_i && !redirect_valid) begin
        if (n_pop < 256) begin
          pop_pc[n_pop]    = fif.fetch_pc_o;
          pop_instr[n_pop] = fif.fetch_instr_o;
          pop_cyc[n_pop]   = cyc;
        end
        n_pop++;
      end
    end
  end

  initial begin
    int bad;
    int good;
    bit found;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    fif.fetch_ready_i = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_mem_req", 32'(fif.mem_req_o), 32'd0);
    check_value("rst_fetch_valid", 32'(fif.fetch_valid_o), 32'd0);
    check_value("rst_fetch_pc", fif.fetch_pc_o, 32'd0);
    check_value("rst_fetch_instr", fif.fetch_instr_o, 32'd0);

    // 1: streaming with 1-cycle latency
    do_reset();
    wait_pops(pb + 3, "t1_pop_timeout");
    check_value("t1_req0", req_log[rb], 32'h0000_0000);
    check_value("t1_req1", req_log[rb + 1], 32'h0000_0004);
    check_value("t1_req2", req_log[rb + 2], 32'h0000_0008);
    check_value("t1_pc0", pop_pc[pb], 32'h0000_0000);
    check_value("t1_in0", pop_instr[pb], 32'h1357_0013);
    check_value("t1_pc1", pop_pc[pb + 1], 32'h0000_0004);
    check_value("t1_in1", pop_instr[pb + 1], 32'h1357_0017);
    check_value("t1_pc2", pop_pc[pb + 2], 32'h0000_0008);
    check_value("t1_in2", pop_instr[pb + 2], 32'h1357_001B);
    check_value("t1_gap", 32'(pop_cyc[pb + 1] - pop_cyc[pb]), 32'd2);

    // 2: decode stalled for 10 cycles
    fif.fetch_ready_i = 1'b0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 6 && fif.mem_req_o) bad++;
    end
    check_value("t2_req_count", 32'(n_req - rb), 32'd2);
    check_value("t2_req_idle", 32'(bad), 32'd0);
    check_value("t2_valid_held", 32'(fif.fetch_valid_o), 32'd1);
    fif.fetch_ready_i = 1'b1;
    wait_pops(pb + 3, "t2_pop_timeout");
    check_value("t2_pc0", pop_pc[pb], 32'h0000_0000);
    check_value("t2_pc1", pop_pc[pb + 1], 32'h0000_0004);
    check_value("t2_req2", req_log[rb + 2], 32'h0000_0008);
    check_value("t2_pc2", pop_pc[pb + 2], 32'h0000_0008);

    // 3: redirect to 0x103 while waiting on 0x8
    lat = 3;
    do_reset();
    wait_reqs(rb + 3, "t3_req_timeout");
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_pops(pb + 3, "t3_pop_timeout");
    check_value("t3_pc1", pop_pc[pb + 1], 32'h0000_0004);
    check_value("t3_req_after", req_log[rb + 3], 32'h0000_0100);
    check_value("t3_pc_after", pop_pc[pb + 2], 32'h0000_0100);
    check_value("t3_in_after", pop_instr[pb + 2], 32'h1357_0113);
`ifdef YARP_FETCH_PERF_EN
    check_value("t3_perf_dropped", perf_dropped, 32'd1);
`endif

    // 4: redirect to 0x200 in the grant cycle of 0x10
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (fif.mem_gnt_i && fif.mem_addr_o == 32'h0000_0010) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
      end
    end
    check_value("t4_found_gnt", 32'(found), 32'd1);
    wait_reqs(rb + 6, "t4_req_timeout");
    check_value("t4_req_stale", req_log[rb + 4], 32'h0000_0010);
    check_value("t4_req_after", req_log[rb + 5], 32'h0000_0200);
    wait_pops(pb + 4, "t4_pop_timeout");
    check_value("t4_pc2", pop_pc[pb + 2], 32'h0000_0008);
    check_value("t4_pc_after", pop_pc[pb + 3], 32'h0000_0200);
    check_value("t4_in_after", pop_instr[pb + 3], 32'h1357_0213);
`ifdef YARP_FETCH_PERF_EN
    check_value("t4_perf_dropped", perf_dropped, 32'd1);
`endif

    // 5: grant withheld for 5 cycles
    gnt_allow = 1'b0;
    do_reset();
    repeat (2) tick();
    good = 0;
    for (int i = 0; i < 5; i++) begin
      if (fif.mem_req_o && fif.mem_addr_o == 32'h0000_0000) good++;
      tick();
    end
    check_value("t5_req_stable", 32'(good), 32'd5);
    check_value("t5_addr", fif.mem_addr_o, 32'h0000_0000);

    // 6: PC wrap from 0xFFFF_FFFC (redirect target also unaligned)
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    rb = n_req;
    pb = n_pop;
    gnt_allow = 1'b1;
    wait_reqs(rb + 2, "t6_req_timeout");
    check_value("t6_req_top", req_log[rb], 32'hFFFF_FFFC);
    check_value("t6_req_wrap", req_log[rb + 1], 32'h0000_0000);
    wait_pops(pb + 1, "t6_pop_timeout");
    check_value("t6_pc_top", pop_pc[pb], 32'hFFFF_FFFC);
    check_value("t6_in_top", pop_instr[pb], 32'hECA8_FFEF);

    // 7: reset while waiting, response lands right after release
    lat = 4;
    keep_on_rst = 1'b0;
    do_reset();
    keep_on_rst = 1'b1;
    wait_reqs(rb + 1, "t7_req_timeout");
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_value("t7_rvalid_now", 32'(fif.mem_rvalid_i), 32'd1);
    rb = n_req;
    pb = n_pop;
    tick();
    check_value("t7_valid_after", 32'(fif.fetch_valid_o), 32'd0);
    wait_reqs(rb + 1, "t7_req2_timeout");
    check_value("t7_first_req", req_log[rb], 32'h0000_0000);
    wait_pops(pb + 1, "t7_pop_timeout");
    check_value("t7_pc0", pop_pc[pb], 32'h0000_0000);
    check_value("t7_in0", pop_instr[pb], 32'h1357_0013);
    keep_on_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
